// File: rtl/weight_load_controller.sv
// Weight load controller: fills ARRAYWIDTH column shifters with ARRAYHEIGHT words each,
// then drives their shift-out enables. Define WEIGHT_SKEW_EN for diagonal (skewed) shift-out.
module weight_load_controller #(
  parameter int DATASIZE    = 8,
  parameter int ARRAYHEIGHT = 4,
  parameter int ARRAYWIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_valid,
  input  logic [DATASIZE-1:0]   w_data,
  output logic                  w_ready,
  input  logic                  shift_req,
  input  logic                  clear,
  output logic [DATASIZE-1:0]   wr_data,
  output logic [ARRAYWIDTH-1:0] load_en,
  output logic [ARRAYWIDTH-1:0] out_en,
  output logic                  loaded,
  output logic                  done
);

`ifdef WEIGHT_SKEW_EN
  localparam int SHIFT_LEN = ARRAYHEIGHT + ARRAYWIDTH - 1;
`else
  localparam int SHIFT_LEN = ARRAYHEIGHT;
`endif

  localparam int ROW_W = (ARRAYHEIGHT > 1) ? $clog2(ARRAYHEIGHT) : 1;
  localparam int COL_W = (ARRAYWIDTH > 1) ? $clog2(ARRAYWIDTH) : 1;
  localparam int K_W   = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;

  localparam logic [ROW_W-1:0]      ROW_LAST = ROW_W'(ARRAYHEIGHT - 1);
  localparam logic [COL_W-1:0]      COL_LAST = COL_W'(ARRAYWIDTH - 1);
  localparam logic [K_W-1:0]        K_LAST   = K_W'(SHIFT_LEN - 1);
  localparam logic [ARRAYWIDTH-1:0] COL_ONE  = ARRAYWIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FULL  = 2'd2,
    SHIFT = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [ROW_W-1:0]        row_q, row_d;
  logic [COL_W-1:0]        col_q, col_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [ARRAYWIDTH-1:0]   out_en_q, out_en_d;
  logic                    done_q, done_d;
  logic                    accept_s;

  // Column enable pattern for shift cycle k; the skewed build staggers columns by one cycle.
  function automatic logic [ARRAYWIDTH-1:0] col_enables(input logic [K_W-1:0] k);
    logic [ARRAYWIDTH-1:0] en;
    en = '0;
    for (int j = 0; j < ARRAYWIDTH; j++) begin
`ifdef WEIGHT_SKEW_EN
      en[j] = (int'(k) >= j) && (int'(k) < j + ARRAYHEIGHT);
`else
      en[j] = (int'(k) < ARRAYHEIGHT);
`endif
    end
    return en;
  endfunction

  // Handshake and per-column load strobe, combinational in the accept cycle.
  always_comb begin
    w_ready  = 1'b0;
    accept_s = 1'b0;
    load_en  = '0;
    wr_data  = w_data;
    loaded   = 1'b0;
    out_en   = out_en_q;
    done     = done_q;
    if (((state_q == IDLE) || (state_q == LOAD)) && !clear) begin
      w_ready = 1'b1;
    end else begin
      w_ready = 1'b0;
    end
    accept_s = w_valid && w_ready;
    if (accept_s) begin
      load_en = COL_ONE << col_q;
    end else begin
      load_en = '0;
    end
    loaded = (state_q == FULL);
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    k_d      = k_q;
    out_en_d = '0;
    done_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      row_d   = '0;
      col_d   = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        IDLE, LOAD: begin
          if (accept_s) begin
            if (row_q == ROW_LAST) begin
              row_d = '0;
              if (col_q == COL_LAST) begin
                state_d = FULL;
                col_d   = '0;
              end else begin
                state_d = LOAD;
                col_d   = col_q + COL_W'(1);
              end
            end else begin
              state_d = LOAD;
              row_d   = row_q + ROW_W'(1);
            end
          end else begin
            state_d = state_q;
          end
        end
        FULL: begin
          if (shift_req) begin
            state_d  = SHIFT;
            k_d      = '0;
            out_en_d = col_enables(K_W'(0));
          end else begin
            state_d = FULL;
          end
        end
        SHIFT: begin
          if (k_q == K_LAST) begin
            state_d = IDLE;
            k_d     = '0;
            done_d  = 1'b1;
          end else begin
            k_d      = k_q + K_W'(1);
            out_en_d = col_enables(k_q + K_W'(1));
          end
        end
        default: begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
          k_d     = '0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      k_q      <= '0;
      out_en_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      k_q      <= k_d;
      out_en_q <= out_en_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_weight_load_controller.sv
// Directed bench for weight_load_controller (H=4, W=4); expectations follow WEIGHT_SKEW_EN.
module tb_weight_load_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       w_valid = 1'b0;
  logic [7:0] w_data = 8'h00;
  logic       w_ready;
  logic       shift_req = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] wr_data;
  logic [3:0] load_en;
  logic [3:0] out_en;
  logic       loaded;
  logic       done;

  int total = 0;
  int bad   = 0;

`ifdef WEIGHT_SKEW_EN
  localparam int S = 7;
  logic [3:0] exp_shift [0:6] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
`else
  localparam int S = 4;
  logic [3:0] exp_shift [0:6] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0};
`endif

  weight_load_controller #(
    .DATASIZE(8), .ARRAYHEIGHT(4), .ARRAYWIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .w_valid(w_valid), .w_data(w_data), .w_ready(w_ready),
    .shift_req(shift_req), .clear(clear), .wr_data(wr_data), .load_en(load_en),
    .out_en(out_en), .loaded(loaded), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then let combinational outputs settle.
  task automatic step(input logic v, input logic [7:0] d, input logic sr, input logic cl);
    @(negedge clk);
    w_valid   = v;
    w_data    = d;
    shift_req = sr;
    clear     = cl;
    #1;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    #1;
    chk("rst_ready", w_ready, 1);
    chk("rst_load_en", load_en, 0);
    chk("rst_out_en", out_en, 0);
    chk("rst_done", done, 0);
    chk("rst_loaded", loaded, 0);
    @(negedge clk);
    rst = 1'b0;

    // Fill 0x01..0x10 with a stall after word 6 and a stray shift_req during LOAD
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i + 1), (i == 3 || i == 10), 1'b0);
      chk("fill_load_en", load_en, 32'd1 << (i / 4));
      chk("fill_wr_data", wr_data, i + 1);
      chk("fill_ready", w_ready, 1);
      chk("fill_loaded", loaded, 0);
      if (i == 5) begin
        for (int s = 0; s < 3; s++) begin
          step(1'b0, 8'hAA, 1'b0, 1'b0);
          chk("stall_load_en", load_en, 0);
          chk("stall_ready", w_ready, 1);
        end
      end
    end
    step(1'b1, 8'h55, 1'b0, 1'b0);
    chk("full_loaded", loaded, 1);
    chk("full_ready", w_ready, 0);
    chk("full_load_en", load_en, 0);

    // Shift-out phase
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("shreq_out_en", out_en, 0);
    chk("shreq_loaded", loaded, 1);
    for (int k = 0; k < S; k++) begin
      step(1'b0, 8'h00, (k == 1), 1'b0);
      chk("shift_out_en", out_en, exp_shift[k]);
      chk("shift_loaded", loaded, 0);
      chk("shift_done", done, 0);
      chk("shift_ready", w_ready, 0);
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("done_pulse", done, 1);
    chk("done_out_en", out_en, 0);
    chk("done_ready", w_ready, 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("done_cleared", done, 0);

    // Clear at word 9 discards progress
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
      chk("pre_clr_load_en", load_en, 32'd1 << (i / 4));
    end
    step(1'b1, 8'h39, 1'b0, 1'b1);
    chk("clr_ready", w_ready, 0);
    chk("clr_load_en", load_en, 0);
    step(1'b1, 8'h21, 1'b0, 1'b0);
    chk("post_clr_load_en", load_en, 1);
    for (int i = 1; i < 16; i++) begin
      step(1'b1, 8'(8'h21 + i), 1'b0, 1'b0);
      chk("refill_load_en", load_en, 32'd1 << (i / 4));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("refill_loaded", loaded, 1);

    // Asynchronous reset at shift cycle k=2
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("k2_out_en", out_en, exp_shift[2]);
    rst = 1'b1;
    #1;
    chk("async_out_en", out_en, 0);
    chk("async_loaded", loaded, 0);
    chk("async_done", done, 0);
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("in_rst_done", done, 0);
      chk("in_rst_out_en", out_en, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 8'h77, 1'b0, 1'b0);
    chk("post_rst_load_en", load_en, 1);
    chk("post_rst_done", done, 0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("post_rst_done2", done, 0);
    chk("post_rst_loaded", loaded, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
